// File: rtl/cl_serial_seq.sv
// Bit-serial sequencer for the 1-bit logic cell `cl`: streams operand bit pairs LSB first
// into the cell and reassembles its outputs into a WIDTH-bit result.
module cl_serial_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             cl_a,
    output logic             cl_b,
    output logic [1:0]       cl_s,
    input  logic             cl_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   sha, sha_nxt;
    logic [WIDTH-1:0]   shb, shb_nxt;
    logic [WIDTH-1:0]   shr, shr_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [1:0]         opr, opr_nxt;
    logic [WIDTH-1:0]   result_nxt;
    logic               zero_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic [WIDTH-1:0]   shr_shift;

    // Operand shifters drain to zero by the end of RUN, so the cell sees 0/0 outside RUN.
    assign cl_a      = sha[0];
    assign cl_b      = shb[0];
    assign cl_s      = opr;
    assign shr_shift = {cl_out, shr[WIDTH-1:1]};

    always_comb begin
        state_nxt  = state;
        sha_nxt    = sha;
        shb_nxt    = shb;
        shr_nxt    = shr;
        cnt_nxt    = cnt;
        opr_nxt    = opr;
        result_nxt = result;
        zero_nxt   = zero;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    sha_nxt   = opa;
                    shb_nxt   = opb;
                    opr_nxt   = op;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                sha_nxt = sha >> 1;
                shb_nxt = shb >> 1;
                shr_nxt = shr_shift;
                if (cnt == CNT_LAST) begin
                    result_nxt = shr_shift;
                    zero_nxt   = (shr_shift == '0);
                    done_nxt   = 1'b1;
                    state_nxt  = S_DONE;
                end else begin
                    cnt_nxt  = cnt + CNT_W'(1);
                    busy_nxt = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            sha    <= '0;
            shb    <= '0;
            shr    <= '0;
            cnt    <= '0;
            opr    <= 2'b00;
            result <= '0;
            zero   <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            sha    <= sha_nxt;
            shb    <= shb_nxt;
            shr    <= shr_nxt;
            cnt    <= cnt_nxt;
            opr    <= opr_nxt;
            result <= result_nxt;
            zero   <= zero_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
        end
    end

endmodule

// File: tb/tb_cl_serial_seq.sv
// Scoreboard bench for cl_serial_seq with a behavioural 1-bit logic cell in the loop.
module tb_cl_serial_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] op;
    logic [7:0] opa, opb;
    logic       cl_a, cl_b, cl_out;
    logic [1:0] cl_s;
    logic       busy, done, zero;
    logic [7:0] result;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int busy_cnt = 0;

    typedef struct {
        logic [7:0] res;
        logic       z;
        int         dcyc;
    } exp_t;

    exp_t exp_q[$];

    cl_serial_seq #(.WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .opa    (opa),
        .opb    (opb),
        .cl_a   (cl_a),
        .cl_b   (cl_b),
        .cl_s   (cl_s),
        .cl_out (cl_out),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero)
    );

    // Behavioural model of the logic cell.
    always_comb begin
        case (cl_s)
            2'b00:   cl_out = cl_a & cl_b;
            2'b01:   cl_out = cl_a | cl_b;
            2'b10:   cl_out = cl_a ^ cl_b;
            default: cl_out = ~cl_a;
        endcase
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("zero", 32'(zero), 32'(e.z));
                chk("done_cycle", 32'(cyc), 32'(e.dcyc));
                chk("busy_len", 32'(busy_cnt), 32'd8);
                chk("busy_at_done", 32'(busy), 32'd0);
            end
            busy_cnt = 0;
        end else if (busy) begin
            busy_cnt++;
        end else begin
            busy_cnt = 0;
        end
    end

    // Drive start at a negedge; returns at the negedge following the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] r, input bit expect_done);
        exp_t e;
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (expect_done) begin
            e.res  = r;
            e.z    = (r == 8'h00);
            e.dcyc = cyc + 8;
            exp_q.push_back(e);
        end
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("cl_s_run", 32'(cl_s), 32'(o));
        chk("cl_a_bit0", 32'(cl_a), 32'(a[0]));
        chk("cl_b_bit0", 32'(cl_b), 32'(b[0]));
        @(negedge clk);
    endtask

    // Waits at negedges for done, bounded.
    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        opa   = 8'h00;
        opb   = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_result", 32'(result), 32'h00);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cl_s", 32'(cl_s), 32'd0);
        chk("rst_cl_ab", 32'({cl_a, cl_b}), 32'd0);

        // AND
        issue(2'b00, 8'hF0, 8'h3C, 8'h30, 1'b1);
        wait_done();
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("result_held", 32'(result), 32'h30);

        // OR then XOR back-to-back from the DONE cycle
        issue(2'b01, 8'hA5, 8'h0F, 8'hAF, 1'b1);
        wait_done();
        issue(2'b10, 8'hFF, 8'h0F, 8'hF0, 1'b1);
        chk("prev_result_while_busy", 32'(result), 32'hAF);
        wait_done();

        // NOT A, then AND giving zero
        repeat (2) @(negedge clk);
        issue(2'b11, 8'h5A, 8'hFF, 8'hA5, 1'b1);
        wait_done();
        issue(2'b00, 8'h55, 8'hAA, 8'h00, 1'b1);
        wait_done();

        // start during RUN is ignored
        repeat (2) @(negedge clk);
        issue(2'b00, 8'hFF, 8'hFF, 8'hFF, 1'b1);
        repeat (2) @(negedge clk);
        start = 1'b1;
        op    = 2'b10;
        opa   = 8'h12;
        opb   = 8'h34;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // reset mid-RUN discards the operation
        repeat (2) @(negedge clk);
        issue(2'b01, 8'h12, 8'h34, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_result", 32'(result), 32'h00);
        chk("mid_rst_zero", 32'(zero), 32'd1);
        chk("mid_rst_cl_s", 32'(cl_s), 32'd0);
        chk("mid_rst_cl_ab", 32'({cl_a, cl_b}), 32'd0);
        repeat (15) @(negedge clk);
        chk("mid_rst_idle_busy", 32'(busy), 32'd0);

        issue(2'b01, 8'h0F, 8'hF0, 8'hFF, 1'b1);
        wait_done();

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cl_serial_seq.md
# cl_serial_seq

Bit-serial sequencer that sits directly upstream of the 1-bit logic cell `cl` and also consumes its output. On `start` it captures two WIDTH-bit operands and a 2-bit function select. It then feeds the cell one operand bit pair per clock, LSB first, and reassembles the cell's outputs into a WIDTH-bit result. The whole logic unit costs a single `cl` instance plus shift registers, and is used as the register-level logic operation stage of the datapath.

## Interface
Parameters:
- `WIDTH`, 8, operand/result width in bits; legal range 2..32.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high; sampled on rising edge of `clk`.
- `start` in 1: request a new operation; accepted only in IDLE or DONE.
- `op` in 2: cell function select, captured with `start`.
- `opa` in WIDTH: operand A, captured with `start`.
- `opb` in WIDTH: operand B, captured with `start`.
- `cl_a` out 1: bit of A presented to the cell.
- `cl_b` out 1: bit of B presented to the cell.
- `cl_s` out 2: function select to the cell.
- `cl_out` in 1: cell output, purely combinational from `cl_a`/`cl_b`/`cl_s`.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse; `result` is valid from this cycle.
- `result` out WIDTH: assembled result, held until the next accepted `start` or `reset`.
- `zero` out 1: high when `result == 0`; updated together with `done`, held with `result`.

## Operation
- Cell functions:
  - `op` 00: A AND B.
  - `op` 01: A OR B.
  - `op` 10: A XOR B.
  - `op` 11: NOT A, with B ignored.
  - The bench's `cl` model implements exactly these.
- FSM states:
  - IDLE: default after reset. `start`=1 captures `opa`→`sha`, `opb`→`shb`, `op`→`opr`, clears `cnt`, and moves to RUN.
  - RUN: each cycle captures `cl_out` into `shr` and shifts `sha`/`shb` right by 1. On the capture with `cnt == WIDTH-1`, moves to DONE; otherwise increments `cnt`.
  - DONE: `done`=1 for exactly one cycle.
    - `start`=1 behaves as in IDLE and moves to RUN, giving back-to-back operation.
    - Otherwise moves to IDLE.
- Cell drive:
  - `cl_a` = `sha[0]` and `cl_b` = `shb[0]` in RUN; both 0 in IDLE and DONE.
  - `cl_s` = `opr` in every state, and is 00 after reset.
- Result assembly:
  - `shr` shifts right with `cl_out` inserted at bit WIDTH-1.
  - After WIDTH captures, `shr[i]` holds the cell output for operand bit i.
  - `result` is loaded from the final `shr` value on entry to DONE. It does not change during RUN, so the previous result stays visible while busy.
- `start` in RUN is ignored: no recapture and no error.
- Operand/op inputs are don't-care except in the cycle where `start` is accepted.
- `cnt` width is `$clog2(WIDTH)`. It never wraps within an operation, because termination is on `cnt == WIDTH-1`.
- Reset, including mid-RUN, takes effect on the next edge:
  - State goes to IDLE and the operation in flight is discarded, with no `done`.
  - `result` = 0 and `zero` = 1.
  - `busy` = 0, `done` = 0, `cl_a` = `cl_b` = 0, `cl_s` = 00.
  - `sha`, `shb`, `shr` and `cnt` are cleared to 0.
- `reset` and `start` asserted in the same cycle: `reset` wins.

## Timing
- Let E0 be the edge at which `start` is accepted.
- After E0: `busy`=1 and `cl_a`/`cl_b` present bit 0.
- Edge E0+k captures cell output bit k-1, for k = 1..WIDTH.
- After E0+WIDTH: `busy`=0, `done`=1, and `result`/`zero` are valid.
- Latency from accepting `start` to `done` is WIDTH cycles.
- `done` is high for one cycle. The earliest next accepted `start` is at edge E0+WIDTH+1, using the DONE-state acceptance.
- Sustained throughput is one operation per WIDTH+1 cycles.
- All outputs are registered except `cl_a` and `cl_b`, which are direct bits of registered shift registers. There is no combinational path from `cl_out` to any output.

## Test plan
All scenarios use WIDTH=8.

- Reset, then idle 3 cycles → `result`=0x00, `zero`=1, `busy`=0, `done`=0, `cl_s`=00, `cl_a`=`cl_b`=0.
- `start` with `op`=00, `opa`=0xF0, `opb`=0x3C → `busy` high for exactly 8 cycles; `done` pulses once 8 cycles after acceptance; `result`=0x30, `zero`=0.
- Back-to-back: `op`=01 with 0xA5/0x0F, then `start` held in the DONE cycle with `op`=10, 0xFF/0x0F → first `result`=0xAF; second `done` 9 cycles after the first; second `result`=0xF0.
- `op`=11, `opa`=0x5A, `opb`=0xFF → `result`=0xA5. Then `op`=00 with 0x55/0xAA → `result`=0x00 and `zero`=1.
- `start` (0xFF/0xFF, `op`=00) asserted again 3 cycles into RUN with different operands → ignored; `done` timing unchanged; `result`=0xFF.
- `reset` asserted 4 cycles into RUN → next cycle is IDLE with `busy`=0 and `result`=0x00, and no `done` pulse ever appears for that operation. A fresh `start` (0x0F OR 0xF0) then yields 0xFF.
